// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
//   Shared constants and types for the 8-way round-robin one-hot arbiter.
//   N       : number of requesters, fixed at 8 to match the encoder_8_3 input
//   IDX_W   : width of a requester index / priority pointer
//   onehot8_t : 8-bit request/grant vector
//   state_e   : arbiter FSM state
// -----------------------------------------------------------------------------
package rr_arb_pkg;

   localparam int N     = 8;
   localparam int IDX_W = 3;

   typedef logic [N-1:0] onehot8_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage : rr_arb_pkg

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
//   Combinational round-robin pick: finds the first set request bit scanning
//   ptr, ptr+1, ..., 7, 0, ..., ptr-1.
// Ports
//   req    in  8  request vector
//   ptr    in  3  highest-priority index for this pick
//   hit    out 1  at least one request set
//   idx    out 3  winning index (0 when hit=0)
//   onehot out 8  one-hot of idx, all zero when hit=0
// -----------------------------------------------------------------------------
module rr_pick8
   import rr_arb_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             hit,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   logic [IDX_W-1:0] pos;

   // Scan from the farthest offset down to offset 0 so the last match written
   // is the one closest to ptr, i.e. the highest-priority requester.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      pos = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = ptr + IDX_W'(k);
         if (req[pos]) begin
            hit = 1'b1;
            idx = pos;
         end
      end
   end

   assign onehot = hit ? (onehot8_t'(1) << idx) : '0;

endmodule : rr_pick8

// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//   Round-robin arbiter over 8 level requests producing a registered one-hot
//   grant with a valid/ready handshake. The grant is held bit-exact until the
//   consumer accepts it; a handshake moves the priority pointer past the
//   granted requester and immediately re-arbitrates (one grant per cycle).
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no grant outstanding, gnt=0, waiting for any request
//   GRANT | one-hot grant presented, held until gnt_ready
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   req        in   8  level requests
//   gnt        out  8  registered one-hot grant, zero when gnt_valid=0
//   gnt_valid  out  1  grant present
//   gnt_ready  in   1  consumer accepts current grant
//   grant_cnt  out 16  completed handshakes, saturating (RR_ARB_STATS_EN only)
//
// Configuration
//   RR_ARB_STATS_EN : when defined, adds the grant_cnt port and counter.
// -----------------------------------------------------------------------------
module rr_onehot_arbiter
   import rr_arb_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_valid,
   input  logic         gnt_ready
`ifdef RR_ARB_STATS_EN
   ,
   output logic [15:0]  grant_cnt
`endif
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   onehot8_t         gnt_q, gnt_d;

   logic [IDX_W-1:0] pick_ptr;
   logic             pick_hit;
   logic [IDX_W-1:0] pick_idx;
   onehot8_t         pick_onehot;
   logic             handshake;

   // While a grant is outstanding the only pick that matters is the one taken
   // at handshake, which starts just past the current winner.
   assign pick_ptr  = (state_q == GRANT) ? gidx_q + IDX_W'(1) : ptr_q;
   assign handshake = (state_q == GRANT) && gnt_ready;

   rr_pick8 u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .hit    (pick_hit),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      gnt_d   = gnt_q;
      if (state_q == IDLE) begin
         if (pick_hit) begin
            state_d = GRANT;
            gidx_d  = pick_idx;
            gnt_d   = pick_onehot;
         end
      end else if (handshake) begin
         ptr_d = pick_ptr;
         if (pick_hit) begin
            gidx_d = pick_idx;
            gnt_d  = pick_onehot;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == GRANT);

`ifdef RR_ARB_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (handshake && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule : rr_onehot_arbiter
